// File: rtl/rs_issue_queue_if.sv
// Dispatch, wakeup, arbiter and issue signals of the 4-entry reservation station.
// master drives the queue inputs; slave is the queue itself.
interface rs_issue_queue_if;
  logic        dispatch_valid_IN;
  logic        dispatch_ready_OUT;
  logic [31:0] dispatch_payload_IN;
  logic [5:0]  dispatch_src1_tag_IN;
  logic [5:0]  dispatch_src2_tag_IN;
  logic        dispatch_src1_rdy_IN;
  logic        dispatch_src2_rdy_IN;
  logic        cdb_valid_IN;
  logic [5:0]  cdb_tag_IN;
  logic [3:0]  requests_OUT;
  logic [3:0]  grants_IN;
  logic        flush_IN;
  logic        issue_valid_OUT;
  logic [31:0] issue_payload_OUT;
  logic [1:0]  issue_slot_OUT;
  logic [2:0]  occupancy_OUT;

  modport master (
    output dispatch_valid_IN, dispatch_payload_IN, dispatch_src1_tag_IN, dispatch_src2_tag_IN,
           dispatch_src1_rdy_IN, dispatch_src2_rdy_IN, cdb_valid_IN, cdb_tag_IN, grants_IN, flush_IN,
    input  dispatch_ready_OUT, requests_OUT, issue_valid_OUT, issue_payload_OUT, issue_slot_OUT,
           occupancy_OUT
  );

  modport slave (
    input  dispatch_valid_IN, dispatch_payload_IN, dispatch_src1_tag_IN, dispatch_src2_tag_IN,
           dispatch_src1_rdy_IN, dispatch_src2_rdy_IN, cdb_valid_IN, cdb_tag_IN, grants_IN, flush_IN,
    output dispatch_ready_OUT, requests_OUT, issue_valid_OUT, issue_payload_OUT, issue_slot_OUT,
           occupancy_OUT
  );
endinterface

// File: rtl/rs_issue_queue.sv
// 4-entry reservation station: CDB wakeup, request/grant issue, flush.
// Issue is registered 1 cycle after grant; dispatch stalls while all entries are valid or flushing.
module rs_issue_queue (
  input  logic            clk_IN,
  input  logic            rst_n_IN,
  rs_issue_queue_if.slave bus
);
  typedef struct packed {
    logic [31:0] payload;
    logic [5:0]  src1_tag;
    logic [5:0]  src2_tag;
    logic        src1_rdy;
    logic        src2_rdy;
  } entry_t;

  entry_t [3:0] ent_q, ent_d;
  logic [3:0]   valid_q, valid_d;
  logic         issue_valid_q, issue_valid_d;
  logic [31:0]  issue_payload_q, issue_payload_d;
  logic [1:0]   issue_slot_q, issue_slot_d;
  logic [2:0]   occ_q, occ_d;

  logic [3:0] req;
  logic [3:0] hon;
  logic [1:0] free_idx;
  logic [1:0] iss_idx;
  logic       dispatch_ready;
  logic       accept;

  function automatic logic cdb_hit(input logic [5:0] tag);
    return bus.cdb_valid_IN && (bus.cdb_tag_IN == tag);
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req[i] = valid_q[i] & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
    end
  end

  assign dispatch_ready = ~(&valid_q) & ~bus.flush_IN;
  assign accept         = bus.dispatch_valid_IN & dispatch_ready;
  assign hon            = req & bus.grants_IN;

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    free_idx = 2'd0;
    iss_idx  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = 2'(i);
      if (hon[i])      iss_idx  = 2'(i);
    end
  end

  always_comb begin
    valid_d         = valid_q;
    ent_d           = ent_q;
    issue_valid_d   = 1'b0;
    issue_payload_d = issue_payload_q;
    issue_slot_d    = issue_slot_q;
    if (bus.flush_IN) begin
      valid_d = '0;
      ent_d   = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (valid_q[i] && cdb_hit(ent_q[i].src1_tag)) ent_d[i].src1_rdy = 1'b1;
        if (valid_q[i] && cdb_hit(ent_q[i].src2_tag)) ent_d[i].src2_rdy = 1'b1;
      end
      if (|hon) begin
        valid_d[iss_idx]          = 1'b0;
        ent_d[iss_idx].src1_rdy   = 1'b0;
        ent_d[iss_idx].src2_rdy   = 1'b0;
        issue_valid_d             = 1'b1;
        issue_payload_d           = ent_q[iss_idx].payload;
        issue_slot_d              = iss_idx;
      end
      // free_idx was invalid at cycle start, so it never collides with the issued slot.
      if (accept) begin
        valid_d[free_idx]          = 1'b1;
        ent_d[free_idx].payload    = bus.dispatch_payload_IN;
        ent_d[free_idx].src1_tag   = bus.dispatch_src1_tag_IN;
        ent_d[free_idx].src2_tag   = bus.dispatch_src2_tag_IN;
        ent_d[free_idx].src1_rdy   = bus.dispatch_src1_rdy_IN | cdb_hit(bus.dispatch_src1_tag_IN);
        ent_d[free_idx].src2_rdy   = bus.dispatch_src2_rdy_IN | cdb_hit(bus.dispatch_src2_tag_IN);
      end
    end
    occ_d = 3'd0;
    for (int i = 0; i < 4; i++) begin
      occ_d = occ_d + {2'b00, valid_d[i]};
    end
  end

  always_ff @(posedge clk_IN or negedge rst_n_IN) begin
    if (!rst_n_IN) begin
      ent_q           <= '0;
      valid_q         <= '0;
      issue_valid_q   <= 1'b0;
      issue_payload_q <= '0;
      issue_slot_q    <= '0;
      occ_q           <= '0;
    end else begin
      ent_q           <= ent_d;
      valid_q         <= valid_d;
      issue_valid_q   <= issue_valid_d;
      issue_payload_q <= issue_payload_d;
      issue_slot_q    <= issue_slot_d;
      occ_q           <= occ_d;
    end
  end

  assign bus.dispatch_ready_OUT = dispatch_ready;
  assign bus.requests_OUT       = req;
  assign bus.issue_valid_OUT    = issue_valid_q;
  assign bus.issue_payload_OUT  = issue_payload_q;
  assign bus.issue_slot_OUT     = issue_slot_q;
  assign bus.occupancy_OUT      = occ_q;
endmodule
